// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

    typedef logic [XLEN-1:0] word_t;

    typedef struct packed {
        word_t pc;
        word_t data;
    } inst_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-unit bus bundle: redirect input, instruction-memory port and decode port.
interface fetch_if;
    import fetch_pkg::*;

    logic  redirect_valid;
    word_t redirect_pc;
    logic  imem_req_valid;
    logic  imem_req_ready;
    word_t imem_addr;
    logic  imem_rsp_valid;
    word_t imem_rsp_data;
    logic  inst_valid;
    logic  inst_ready;
    word_t inst_data;
    word_t inst_pc;
    word_t inst_pc4;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        output imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc, inst_pc4
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        input  imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc, inst_pc4
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; DEPTH must be a power of two.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// Program counter, credit-limited in-order imem reads, and decode-side buffering with redirect flush.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter word_t       RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned DEPTH    = 2
) (
    input logic     clk,
    input logic     reset,
    fetch_if.master bus
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    word_t         pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] inflight_next;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] occupancy;
    logic [CW-1:0] tag_count;
    logic [CW:0]   credits_used;
    logic          tag_full;
    logic          instr_full;
    logic          instr_empty;
    logic          req_fire;
    logic          rsp_fire;
    logic          rsp_keep;
    logic          inst_fire;
    word_t         tag_head;
    inst_entry_t   instr_in;
    inst_entry_t   instr_head;

    assign credits_used = {1'b0, inflight} + {1'b0, occupancy};
    assign bus.imem_req_valid = !reset && !bus.redirect_valid && !tag_full
                              && (credits_used < (CW+1)'(DEPTH));
    assign bus.imem_addr = pc;
    assign req_fire      = bus.imem_req_valid && bus.imem_req_ready;

    // a response with nothing outstanding is a protocol error and is ignored
    assign rsp_fire      = bus.imem_rsp_valid && (inflight != '0);
    assign rsp_keep      = rsp_fire && (drop_cnt == '0) && (tag_count != '0)
                         && !instr_full && !bus.redirect_valid;
    assign inflight_next = inflight + CW'(req_fire) - CW'(rsp_fire);

    assign instr_empty = (occupancy == '0);
    assign inst_fire   = !instr_empty && bus.inst_ready;
    assign instr_in    = '{pc: tag_head, data: bus.imem_rsp_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            inflight <= inflight_next;
            if (bus.redirect_valid) begin
                pc <= bus.redirect_pc & ~word_t'(3);
                // everything still outstanding after this cycle is stale, older drops included
                drop_cnt <= inflight_next;
            end else begin
                if (req_fire) pc <= pc + word_t'(4);
                if (rsp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (bus.redirect_valid),
        .push  (req_fire),
        .wdata (pc),
        .pop   (rsp_keep),
        .rdata (tag_head),
        .full  (tag_full),
        .count (tag_count)
    );

    fetch_fifo #(.WIDTH($bits(inst_entry_t)), .DEPTH(DEPTH)) u_instr_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (bus.redirect_valid),
        .push  (rsp_keep),
        .wdata (instr_in),
        .pop   (inst_fire),
        .rdata (instr_head),
        .full  (instr_full),
        .count (occupancy)
    );

    assign bus.inst_valid = !instr_empty;
    assign bus.inst_data  = instr_empty ? '0 : instr_head.data;
    assign bus.inst_pc    = instr_empty ? '0 : instr_head.pc;
    assign bus.inst_pc4   = instr_empty ? '0 : instr_head.pc + word_t'(4);

endmodule
